// File: rtl/imem_pkg.sv
// Shared constants, types and helpers for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state to the loader state encoding.
package imem_pkg;

  localparam int INSTR_W = 13;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int CNT_W   = 6;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd5,
`endif
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic count_legal(input logic [CNT_W-1:0] n);
    return (n != {CNT_W{1'b0}}) && (n <= CNT_W'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master drives the stream and observes writes; slave is the loader.
interface imem_loader_if;
  import imem_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  addr_t      wr_addr;
  instr_t     wr_data;

  modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
  modport slave  (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);

endinterface

// File: rtl/byte_pair_asm.sv
// Assembles a 13-bit instruction from a low byte and the low 5 bits of a high byte.
// The caller strobes take_lo/take_hi on accepted handshakes; word is registered.
module byte_pair_asm
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       take_lo,
  input  logic       take_hi,
  input  logic [7:0] byte_in,
  output instr_t     word,
  output logic       hi_bad
);

  logic [7:0] low_r;
  instr_t     word_r;

  // Low byte capture and word assembly on the high byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_r  <= 8'd0;
      word_r <= {INSTR_W{1'b0}};
    end else begin
      if (take_lo) begin
        low_r <= byte_in;
      end
      if (take_hi) begin
        word_r <= {byte_in[4:0], low_r};
      end
    end
  end

  assign word   = word_r;
  assign hi_bad = (byte_in[7:5] != 3'd0);

endmodule

// File: rtl/imem_loader.sv
// Program loader: byte stream -> 13-bit words written from address 0; holds fetch until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module imem_loader
  import imem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_words,
  imem_loader_if.slave         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_hold
);

  state_t state_r, state_next_s;
  addr_t  addr_r, addr_next_s;
  addr_t  last_r, last_next_s;
  logic   err_r, err_next_s;
  logic   in_ready_r, wr_en_r, busy_r, done_r, hold_r;
  logic   ready_next_s, wr_next_s, busy_next_s, done_next_s, hold_next_s;
  logic   take_lo_s, take_hi_s, xfer_s, hi_bad_s;
  instr_t word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_r, csum_next_s;
`endif

  assign xfer_s = bus.in_valid & in_ready_r;

  byte_pair_asm u_asm (
    .clk     (clk),
    .reset   (reset),
    .take_lo (take_lo_s),
    .take_hi (take_hi_s),
    .byte_in (bus.in_data),
    .word    (word_s),
    .hi_bad  (hi_bad_s)
  );

  // Next-state, address and error logic.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    last_next_s  = last_r;
    err_next_s   = err_r;
    take_lo_s    = 1'b0;
    take_hi_s    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next_s  = csum_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (count_legal(num_words)) begin
            state_next_s = ST_LO;
            addr_next_s  = {ADDR_W{1'b0}};
            last_next_s  = ADDR_W'(num_words - CNT_W'(1));
            err_next_s   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_next_s  = 8'd0;
`endif
          end else begin
            state_next_s = ST_IDLE;
            err_next_s   = 1'b1;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LO: begin
        if (xfer_s) begin
          take_lo_s    = 1'b1;
          state_next_s = ST_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next_s  = csum_r ^ bus.in_data;
`endif
        end else begin
          state_next_s = ST_LO;
        end
      end
      ST_HI: begin
        if (xfer_s) begin
          take_hi_s    = 1'b1;
          state_next_s = ST_WRITE;
          // A bad high byte still produces a write; only the flag records it.
          if (hi_bad_s) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_r;
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next_s  = csum_r ^ bus.in_data;
`endif
        end else begin
          state_next_s = ST_HI;
        end
      end
      ST_WRITE: begin
        if (addr_r == last_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next_s = ST_CHK;
`else
          state_next_s = ST_DONE;
`endif
        end else begin
          addr_next_s  = addr_r + ADDR_W'(1);
          state_next_s = ST_LO;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          state_next_s = ST_DONE;
          if (bus.in_data != csum_r) begin
            err_next_s = 1'b1;
          end else begin
            err_next_s = err_r;
          end
        end else begin
          state_next_s = ST_CHK;
        end
      end
`endif
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every status output comes from a flop.
  always_comb begin
    ready_next_s = 1'b0;
    wr_next_s    = 1'b0;
    busy_next_s  = 1'b0;
    done_next_s  = 1'b0;
    hold_next_s  = 1'b1;
    case (state_next_s)
      ST_LO, ST_HI: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b1;
      end
      ST_WRITE: begin
        wr_next_s   = 1'b1;
        busy_next_s = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b1;
      end
`endif
      ST_DONE: begin
        done_next_s = 1'b1;
        hold_next_s = 1'b0;
      end
      default: begin
        hold_next_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      last_r     <= {ADDR_W{1'b0}};
      err_r      <= 1'b0;
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hold_r     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      state_r    <= state_next_s;
      addr_r     <= addr_next_s;
      last_r     <= last_next_s;
      err_r      <= err_next_s;
      in_ready_r <= ready_next_s;
      wr_en_r    <= wr_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      hold_r     <= hold_next_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= csum_next_s;
`endif
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = addr_r;
  assign bus.wr_data  = word_s;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign cpu_hold     = hold_r;

endmodule
